// File: rtl/window_counter_pkg.sv
// ---------------------------------------------------------------------------
// window_counter_pkg
// Shared types and constants for the window_counter block.
//   state_t      : FSM state encoding (ST_RUN / ST_HOLD)
//   DIR_UP/DOWN  : encodings of the `up` direction input
//   LIM_WRAP/SAT : encodings of the `sat` limit-mode input
// ---------------------------------------------------------------------------
package window_counter_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_RUN  = 1'b0;
   localparam state_t ST_HOLD = 1'b1;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam logic LIM_WRAP = 1'b0;
   localparam logic LIM_SAT  = 1'b1;

endpackage

// File: rtl/window_counter_if.sv
// ---------------------------------------------------------------------------
// window_counter_if
// Control/status bundle of the window counter.
//   Controls (master -> slave): clr, load, load_val, en, up, sat, oneshot,
//                               lo, hi
//   Status   (slave -> master): q, in_window, tc, ovf, holding
// The counter itself connects through the slave modport.
// ---------------------------------------------------------------------------
interface window_counter_if
   import window_counter_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up;
   logic             sat;
   logic             oneshot;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;

   logic [WIDTH-1:0] q;
   logic             in_window;
   logic             tc;
   logic             ovf;
   logic             holding;

   modport master (
      output clr, load, load_val, en, up, sat, oneshot, lo, hi,
      input  q, in_window, tc, ovf, holding
   );

   modport slave (
      input  clr, load, load_val, en, up, sat, oneshot, lo, hi,
      output q, in_window, tc, ovf, holding
   );

endinterface

// File: rtl/window_counter_compare.sv
// ---------------------------------------------------------------------------
// window_compare
// Combinational inclusive range check: in_window_o = lo_i <= val_i <= hi_i.
// An inverted range (lo_i > hi_i) is treated as empty.
//   val_i       : value under test
//   lo_i, hi_i  : inclusive bounds
//   in_window_o : 1 when val_i lies inside the window
// ---------------------------------------------------------------------------
module window_compare
   import window_counter_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic [WIDTH-1:0] val_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] hi_i,
   output logic             in_window_o
);

   assign in_window_o = (lo_i <= hi_i) && (val_i >= lo_i) && (val_i <= hi_i);

endmodule

// File: rtl/window_counter.sv
// ---------------------------------------------------------------------------
// window_counter
// Up/down counter with load, wrap/saturate and one-shot modes, plus a
// registered window flag that always describes the current count.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : window_counter_if slave (controls in, count/flags out)
// Priority each edge: reset > clr > load > count.
// ---------------------------------------------------------------------------
module window_counter
   import window_counter_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic       clk,
   input  logic       reset,
   window_counter_if.slave bus
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             in_window_q, in_window_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   state_t           state_q, state_d;

   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] stepped;
   logic             at_term;

   always_comb begin
      // Terminal follows the current direction input, so flipping `up`
      // moves the terminal immediately.
      term_val = (bus.up == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      // Modulo arithmetic: stepping past terminal is exactly the wrap value.
      stepped  = (bus.up == DIR_DOWN) ? count_q - 1'b1 : count_q + 1'b1;
      at_term  = (count_q == term_val);

      count_d = count_q;
      state_d = state_q;
      ovf_d   = ovf_q;
      tc_d    = 1'b0;

      if (bus.clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
         state_d = ST_RUN;
      end else if (bus.load) begin
         count_d = bus.load_val;
         state_d = ST_RUN;
      end else if (state_q == ST_RUN && bus.en) begin
         if (!at_term) begin
            count_d = stepped;
            if (stepped == term_val) begin
               tc_d = 1'b1;
               if (bus.oneshot) begin
                  state_d = ST_HOLD;
               end
            end
         end else begin
            ovf_d = 1'b1;
            if (bus.oneshot) begin
               // One-shot parks on terminal whatever the limit mode.
               state_d = ST_HOLD;
            end else begin
               case (bus.sat)
                  LIM_WRAP: count_d = stepped;
                  LIM_SAT:  count_d = count_q;
               endcase
            end
         end
      end
   end

   // Window flag is evaluated on the next count so it lands with it.
   window_compare #(
      .WIDTH (WIDTH)
   ) u_compare (
      .val_i       (count_d),
      .lo_i        (bus.lo),
      .hi_i        (bus.hi),
      .in_window_o (in_window_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         in_window_q <= 1'b0;
         tc_q        <= 1'b0;
         ovf_q       <= 1'b0;
         state_q     <= ST_RUN;
      end else begin
         count_q     <= count_d;
         in_window_q <= in_window_d;
         tc_q        <= tc_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
      end
   end

   assign bus.q         = count_q;
   assign bus.in_window = in_window_q;
   assign bus.tc        = tc_q;
   assign bus.ovf       = ovf_q;
   assign bus.holding   = (state_q == ST_HOLD);

endmodule

// File: tb/tb_window_counter.sv
`timescale 1ns/1ps
module tb_window_counter;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] q;
      logic         inw;
      logic         tc;
      logic         ovf;
      logic         hold;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   exp_t sb[$];

   // reference model state
   logic [W-1:0] m_q    = '0;
   logic         m_inw  = 1'b0;
   logic         m_tc   = 1'b0;
   logic         m_ovf  = 1'b0;
   logic         m_hold = 1'b0;

   window_counter_if #(.WIDTH(W)) bus ();

   window_counter #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, required %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic c, input logic l, input logic [W-1:0] lv,
                        input logic e, input logic u, input logic s, input logic o);
      bus.clr      = c;
      bus.load     = l;
      bus.load_val = lv;
      bus.en       = e;
      bus.up       = u;
      bus.sat      = s;
      bus.oneshot  = o;
   endtask

   // Behavioural model of one clock edge, written from the block description.
   task automatic model_step();
      logic [W-1:0] term;
      term = bus.up ? 4'hF : 4'h0;
      m_tc = 1'b0;
      if (bus.clr) begin
         m_q = '0; m_ovf = 1'b0; m_hold = 1'b0;
      end else if (bus.load) begin
         m_q = bus.load_val; m_hold = 1'b0;
      end else if (!m_hold && bus.en) begin
         if (m_q != term) begin
            m_q = bus.up ? m_q + 4'd1 : m_q - 4'd1;
            if (m_q == term) begin
               m_tc = 1'b1;
               if (bus.oneshot) m_hold = 1'b1;
            end
         end else begin
            m_ovf = 1'b1;
            if (bus.oneshot)  m_hold = 1'b1;
            else if (!bus.sat) m_q = bus.up ? 4'h0 : 4'hF;
         end
      end
      m_inw = (m_q >= bus.lo) && (m_q <= bus.hi);
   endtask

   task automatic step(input string tag);
      exp_t e;
      model_step();
      sb.push_back('{q: m_q, inw: m_inw, tc: m_tc, ovf: m_ovf, hold: m_hold});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         $display("[TB] %s q=%0d in_window=%0d tc=%0d ovf=%0d holding=%0d", tag,
                  bus.q, bus.in_window, bus.tc, bus.ovf, bus.holding);
         check({tag, ".q"},         32'(bus.q),         32'(e.q));
         check({tag, ".in_window"}, 32'(bus.in_window), 32'(e.inw));
         check({tag, ".tc"},        32'(bus.tc),        32'(e.tc));
         check({tag, ".ovf"},       32'(bus.ovf),       32'(e.ovf));
         check({tag, ".holding"},   32'(bus.holding),   32'(e.hold));
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".q"},         32'(bus.q),         32'd0);
      check({tag, ".in_window"}, 32'(bus.in_window), 32'd0);
      check({tag, ".tc"},        32'(bus.tc),        32'd0);
      check({tag, ".ovf"},       32'(bus.ovf),       32'd0);
      check({tag, ".holding"},   32'(bus.holding),   32'd0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.lo = 4'd7;
      bus.hi = 4'd14;
      #1;
      check_reset_state("reset_hold");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // idle edge after release: q stays 0, window 7..14 excludes it
      step("idle");

      // window sweep: up, wrap, 20 counts from 0
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step("sweep");

      // count on to 9, then assert reset asynchronously mid-cycle
      for (int i = 0; i < 5; i++) step("precount");
      check("precount.q_is_9", 32'(bus.q), 32'd9);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("async_reset");
      m_q = '0; m_inw = 1'b0; m_tc = 1'b0; m_ovf = 1'b0; m_hold = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state("reset_low_edge");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step("resume");

      // saturate down from a load of 2
      drive(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      step("sat_load");
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step("sat");

      // one-shot up from 13, then reload
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      step("os_clr");
      drive(1'b0, 1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 1'b1);
      step("os_load");
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step("oneshot");
      drive(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      step("os_reload");

      // priority: clr beats load, terminal load gives no tc, load beats count
      drive(1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      step("clr_load");
      drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
      step("load_term");
      drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      step("load_vs_count");
      drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
      step("load_15");
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("dir_flip");

      // empty window across a full sweep
      bus.lo = 4'd10;
      bus.hi = 4'd5;
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("empty_clr");
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) step("empty");

      // random mix of all controls
      for (int i = 0; i < 150; i++) begin
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
         bus.lo = 4'($urandom_range(0, 15));
         bus.hi = 4'($urandom_range(0, 15));
         step("random");
      end

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/window_counter.md
# window_counter

Parametrised up/down counter with load, wrap/saturate and one-shot modes, plus a programmable window flag aligned with the count. Successor to the team's fixed 4-bit counter with hard-wired 7..14 "upper" flag. Used wherever a block needs a configurable timebase, range detector or terminal-count event.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width in bits; legal range 2..32.

**Ports**
- `clk`, input, 1: clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `clr`, input, 1: synchronous clear of the count, sticky flag and state.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, WIDTH: value loaded when `load`=1.
- `en`, input, 1: count enable.
- `up`, input, 1: direction; 1 counts up, 0 counts down.
- `sat`, input, 1: limit behaviour; 1 saturates, 0 wraps.
- `oneshot`, input, 1: 1 stops the counter in HOLD on reaching terminal.
- `lo`, input, WIDTH: window lower bound, inclusive.
- `hi`, input, WIDTH: window upper bound, inclusive.
- `q`, output, WIDTH: count value.
- `in_window`, output, 1: registered; `lo` ≤ `q` ≤ `hi`.
- `tc`, output, 1: registered one-cycle pulse on reaching terminal by counting.
- `ovf`, output, 1: sticky; a count was attempted past terminal.
- `holding`, output, 1: FSM is in HOLD.

## Operation

- **Terminal value:** `MAX` = 2^WIDTH−1 when `up`=1; 0 when `up`=0. Arithmetic is unsigned and modulo 2^WIDTH.
- **Priority each edge:** `reset` > `clr` > `load` > count.
- **`clr`:** `q`=0, `ovf`=0, `tc`=0, state RUN.
- **`load`:** `q`=`load_val`, state RUN, `tc`=0. `ovf` is unchanged. `en` is ignored that cycle.
- **FSM:**
  - Two states: RUN and HOLD. Reset state is RUN.
  - RUN with `en`=1 and `q` not terminal: step `q` by ±1. If the new value is terminal, `tc`=1. If the new value is terminal and `oneshot`=1, go to HOLD.
  - RUN with `en`=1 and `q` terminal: set `ovf`. If `sat`=1, `q` holds. If `sat`=0, `q` wraps (MAX→0 or 0→MAX) and `tc`=0.
  - If `oneshot`=1 and `q` is terminal, the state goes to HOLD regardless of `sat`.
  - HOLD: `q` frozen, `en` ignored, `holding`=1. Leave only via `load` or `clr`.
- **`in_window`:** computed from next-`q` and registered with `q`, so it always describes the current `q` with zero lag. If `lo` > `hi`, the window is empty and `in_window`=0.
- **Inputs and state:** `up`, `sat`, `oneshot`, `lo`, `hi` may change any cycle and take effect on the next edge. Changing `up` changes which value is terminal immediately.

## Timing

- **Reset values:** `q`=0, `in_window`=(`lo`==0) evaluated at the first edge after release. During reset `in_window`=0, `tc`=0, `ovf`=0, `holding`=0, state RUN.
- **Reset assertion:** asynchronous, takes effect immediately, including mid-count or in HOLD. Release is synchronised by the clock only.
- **Latency:**
  - `q`, `in_window`, `tc`, `ovf` and `holding` all update on the same edge that applies the operation (one edge, no extra pipeline).
  - `tc` is high for exactly one cycle per terminal arrival. It is not asserted for a terminal value arriving via `load`.
- **Simultaneous events:**
  - `load` together with a terminal count: load wins, no `tc`, no `ovf`.
  - `clr` together with `load`: clr wins.

## Structure

- **Package `window_counter_pkg`:**
  - state typedef: RUN, HOLD.
  - direction constants: `DIR_UP`=1, `DIR_DOWN`=0.
  - limit-mode constants: `LIM_WRAP`=0, `LIM_SAT`=1.
- **Sub-module `window_compare`:** combinational, parametrised by WIDTH. Takes a value, `lo` and `hi` and returns the in-window bit. Instantiated on next-`q`.
- **Top level:** next-state/next-count logic plus output registers.

## Test plan

- **Reset:** WIDTH=4, `lo`=7, `hi`=14; pulse `reset` low mid-count at `q`=9. Required: `q`=0 immediately, all flags 0; counting resumes from 0 after release.
- **Window sweep:** up, wrap, `en`=1 for 20 cycles from 0. Required: `in_window`=1 exactly when `q`∈7..14, in the same cycle. `tc` pulses when `q`=15. `q` wraps to 0 with `ovf`=1.
- **Saturate:** down, `sat`=1, `load_val`=2. Required: `q` goes 2,1,0,0,0. `tc` pulses once at 0. `ovf` rises on the cycle after reaching 0. `holding`=0.
- **One-shot:** up, `oneshot`=1, load 13. Required: `q` goes 14,15 then freezes. `tc` at 15, `holding`=1. Then `load`=3 gives `q`=3 and `holding`=0.
- **Priority and empty window:** `clr`+`load` in the same cycle gives `q`=0. `load` of 15 while up gives no `tc`. `lo`=10, `hi`=5 keeps `in_window`=0 across a full sweep.
